// File: rtl/memory_dp_io_if.sv
// Bus bundle between the processor/board side and memory_dp_io: fetch port,
// read/write data port, status flags and the two I/O word handshakes.
interface memory_dp_io_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 9
);
    logic [ADDR_WIDTH-1:0] FetchAddr;
    logic [DATA_WIDTH-1:0] FetchVal;
    logic [ADDR_WIDTH-1:0] Address;
    logic [DATA_WIDTH-1:0] DataIn;
    logic                  MemWrite;
    logic                  MemRead;
    logic [DATA_WIDTH-1:0] MemVal;
    logic                  Ready;
    logic                  Stall;
    logic [DATA_WIDTH-1:0] IoOut;
    logic                  IoOutValid;
    logic                  IoOutAck;
    logic [DATA_WIDTH-1:0] IoIn;
    logic                  IoInValid;
    logic                  IoInAck;

    modport master (
        output FetchAddr, Address, DataIn, MemWrite, MemRead, IoOutAck, IoIn, IoInValid,
        input  FetchVal, MemVal, Ready, Stall, IoOut, IoOutValid, IoInAck
    );

    modport slave (
        input  FetchAddr, Address, DataIn, MemWrite, MemRead, IoOutAck, IoIn, IoInValid,
        output FetchVal, MemVal, Ready, Stall, IoOut, IoOutValid, IoInAck
    );
endinterface

// File: rtl/memory_dp_io.sv
// Program/data memory with a read-only fetch port, a read/write data port,
// a post-reset clear sweep of the data region, and one memory-mapped I/O word
// (IO_ADDR) backed by valid/ack handshakes instead of storage.
module memory_dp_io #(
    parameter int    DATA_WIDTH = 16,
    parameter int    ADDR_WIDTH = 9,
    parameter string INIT_FILE  = "program.mem",
    parameter int    DATA_BASE  = 256,
    parameter int    IO_ADDR    = (1 << ADDR_WIDTH) - 1
) (
    input logic           clock,
    input logic           reset,
    memory_dp_io_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] BASE_A = ADDR_WIDTH'(DATA_BASE);
    localparam logic [ADDR_WIDTH-1:0] IO_A   = ADDR_WIDTH'(IO_ADDR);
    localparam logic [ADDR_WIDTH-1:0] LAST_A = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic {SWEEP, RUN} state_t;

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] ptr;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  is_io;
    logic                  ready, stall;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  io_wr_ok;   // I/O output word is captured this edge
    logic                  io_rd_ok;   // I/O input word is consumed this edge

    assign is_io     = (bus.Address == IO_A);
    assign bus.Ready = ready;
    assign bus.Stall = stall;

    // State register: reset always restarts the clear sweep.
    always_ff @(posedge clock) begin
        if (reset) state <= SWEEP;
        else       state <= state_nxt;
    end

    // Next state, flags and decode of the data-port request.
    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        stall     = 1'b0;
        mem_we    = 1'b0;
        wr_addr   = bus.Address;
        wr_data   = bus.DataIn;
        io_wr_ok  = 1'b0;
        io_rd_ok  = 1'b0;
        case (state)
            SWEEP: begin
                // Port strobes are ignored; the write port belongs to the sweep.
                stall   = 1'b1;
                mem_we  = 1'b1;
                wr_addr = ptr;
                wr_data = '0;
                if (ptr == LAST_A) state_nxt = RUN;
            end
            RUN: begin
                ready = 1'b1;
                if (bus.MemWrite) begin
                    if (is_io) begin
                        // An ack in the same cycle frees the slot for the new word.
                        if (!bus.IoOutValid || bus.IoOutAck) io_wr_ok = 1'b1;
                        else                                 stall    = 1'b1;
                    end else begin
                        mem_we = 1'b1;
                    end
                end else if (is_io && bus.MemRead) begin
                    if (bus.IoInValid) io_rd_ok = 1'b1;
                    else               stall    = 1'b1;
                end
            end
            default: state_nxt = SWEEP;
        endcase
    end

    // Storage: the single write port.
    always_ff @(posedge clock) begin
        if (!reset && mem_we) mem[wr_addr] <= wr_data;
    end

    // Sweep pointer, registered read ports and I/O handshake state.
    always_ff @(posedge clock) begin
        if (reset) begin
            ptr            <= BASE_A;
            bus.FetchVal   <= '0;
            bus.MemVal     <= '0;
            bus.IoOut      <= '0;
            bus.IoOutValid <= 1'b0;
            bus.IoInAck    <= 1'b0;
        end else begin
            bus.IoInAck <= io_rd_ok;
            if (state == SWEEP) begin
                ptr <= ptr + ADDR_WIDTH'(1);
            end else begin
                // Read-first: a same-address write this edge is not visible here.
                bus.FetchVal <= mem[bus.FetchAddr];
                if (!bus.MemWrite) begin
                    if (!is_io)        bus.MemVal <= mem[bus.Address];
                    else if (io_rd_ok) bus.MemVal <= bus.IoIn;
                end
                if (io_wr_ok) begin
                    bus.IoOut      <= bus.DataIn;
                    bus.IoOutValid <= 1'b1;
                end else if (bus.IoOutAck) begin
                    bus.IoOutValid <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_memory_dp_io.sv
// Directed bench for memory_dp_io: reset/sweep timing, data port, read-first
// fetch, write-wins collision, I/O output and input handshakes, sweep restart.
module tb_memory_dp_io;
    logic clock = 1'b0;
    logic reset = 1'b0;
    int   total = 0;
    int   bad   = 0;

    memory_dp_io_if #(.DATA_WIDTH(16), .ADDR_WIDTH(9)) bus ();

    memory_dp_io #(
        .DATA_WIDTH(16), .ADDR_WIDTH(9), .INIT_FILE(""), .DATA_BASE(256), .IO_ADDR(511)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    // Watchdog: never let the run hang.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        bus.MemWrite  = 1'b0;
        bus.MemRead   = 1'b0;
        bus.IoOutAck  = 1'b0;
        bus.IoInValid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (n < 400) begin
            tick();
            n++;
            if (bus.Ready === 1'b1) break;
        end
    endtask

    task automatic test_reset();
        int n;
        do_reset();
        total++; if (bus.Ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%0b exp=0", bus.Ready); end
        total++; if (bus.Stall !== 1'b1) begin bad++; $display("FAIL reset_stall got=%0b exp=1", bus.Stall); end
        total++; if (bus.MemVal !== 16'h0 || bus.FetchVal !== 16'h0 || bus.IoOut !== 16'h0) begin
            bad++; $display("FAIL reset_data MemVal=%h FetchVal=%h IoOut=%h exp=0", bus.MemVal, bus.FetchVal, bus.IoOut);
        end
        total++; if (bus.IoOutValid !== 1'b0 || bus.IoInAck !== 1'b0) begin
            bad++; $display("FAIL reset_io IoOutValid=%0b IoInAck=%0b exp=0", bus.IoOutValid, bus.IoInAck);
        end
        wait_ready(n);
        total++; if (n !== 256) begin bad++; $display("FAIL ready_latency got=%0d exp=256", n); end
        bus.Address = 9'd300;
        tick();
        total++; if (bus.MemVal !== 16'h0) begin bad++; $display("FAIL sweep_clear got=%h exp=0000", bus.MemVal); end
    endtask

    task automatic test_rw();
        bus.Address = 9'h10; bus.DataIn = 16'h5555; bus.MemWrite = 1'b1;
        tick();
        bus.DataIn = 16'h1234; bus.FetchAddr = 9'h10;
        tick();
        total++; if (bus.FetchVal !== 16'h5555) begin bad++; $display("FAIL fetch_read_first got=%h exp=5555", bus.FetchVal); end
        total++; if (bus.MemVal !== 16'h0) begin bad++; $display("FAIL memval_hold_on_write got=%h exp=0000", bus.MemVal); end
        bus.MemWrite = 1'b0;
        tick();
        total++; if (bus.MemVal !== 16'h1234) begin bad++; $display("FAIL data_read got=%h exp=1234", bus.MemVal); end
        total++; if (bus.FetchVal !== 16'h1234) begin bad++; $display("FAIL fetch_new got=%h exp=1234", bus.FetchVal); end
    endtask

    task automatic test_write_wins();
        bus.Address = 9'h30; bus.DataIn = 16'h1111; bus.MemWrite = 1'b1;
        tick();
        bus.MemWrite = 1'b0;
        tick();
        total++; if (bus.MemVal !== 16'h1111) begin bad++; $display("FAIL read_30 got=%h exp=1111", bus.MemVal); end
        bus.Address = 9'h20; bus.DataIn = 16'hBEEF; bus.MemWrite = 1'b1; bus.MemRead = 1'b1;
        tick();
        total++; if (bus.MemVal !== 16'h1111) begin bad++; $display("FAIL wr_rd_memval got=%h exp=1111", bus.MemVal); end
        idle();
        tick();
        total++; if (bus.MemVal !== 16'hBEEF) begin bad++; $display("FAIL wr_rd_stored got=%h exp=beef", bus.MemVal); end
    endtask

    task automatic test_io_out();
        idle();
        bus.Address = 9'd511; bus.DataIn = 16'h00AA; bus.MemWrite = 1'b1;
        #1;
        total++; if (bus.Stall !== 1'b0) begin bad++; $display("FAIL io_wr1_stall got=%0b exp=0", bus.Stall); end
        tick();
        total++; if (bus.IoOut !== 16'h00AA || bus.IoOutValid !== 1'b1) begin
            bad++; $display("FAIL io_wr1 IoOut=%h valid=%0b exp=00aa/1", bus.IoOut, bus.IoOutValid);
        end
        bus.DataIn = 16'h0055;
        #1;
        total++; if (bus.Stall !== 1'b1) begin bad++; $display("FAIL io_wr2_stall got=%0b exp=1", bus.Stall); end
        tick();
        tick();
        total++; if (bus.Stall !== 1'b1 || bus.IoOut !== 16'h00AA) begin
            bad++; $display("FAIL io_wr2_held Stall=%0b IoOut=%h exp=1/00aa", bus.Stall, bus.IoOut);
        end
        bus.IoOutAck = 1'b1;
        #1;
        total++; if (bus.Stall !== 1'b0) begin bad++; $display("FAIL io_ack_stall got=%0b exp=0", bus.Stall); end
        tick();
        total++; if (bus.IoOut !== 16'h0055 || bus.IoOutValid !== 1'b1) begin
            bad++; $display("FAIL io_replace IoOut=%h valid=%0b exp=0055/1", bus.IoOut, bus.IoOutValid);
        end
        bus.MemWrite = 1'b0; bus.Address = 9'h10;
        tick();
        total++; if (bus.IoOutValid !== 1'b0) begin bad++; $display("FAIL io_ack_clear got=%0b exp=0", bus.IoOutValid); end
        idle();
    endtask

    task automatic test_io_in();
        // MemVal is mem[0x10]=1234 from the previous cycles' reads.
        bus.Address = 9'd511; bus.MemRead = 1'b1; bus.IoInValid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++; if (bus.Stall !== 1'b1) begin bad++; $display("FAIL io_rd_stall cyc=%0d got=%0b exp=1", i, bus.Stall); end
            tick();
        end
        total++; if (bus.IoInAck !== 1'b0 || bus.MemVal !== 16'h1234) begin
            bad++; $display("FAIL io_rd_wait ack=%0b MemVal=%h exp=0/1234", bus.IoInAck, bus.MemVal);
        end
        bus.IoIn = 16'h0042; bus.IoInValid = 1'b1;
        #1;
        total++; if (bus.Stall !== 1'b0) begin bad++; $display("FAIL io_rd_go_stall got=%0b exp=0", bus.Stall); end
        tick();
        total++; if (bus.MemVal !== 16'h0042 || bus.IoInAck !== 1'b1) begin
            bad++; $display("FAIL io_rd MemVal=%h ack=%0b exp=0042/1", bus.MemVal, bus.IoInAck);
        end
        bus.MemRead = 1'b0; bus.IoInValid = 1'b0;
        tick();
        total++; if (bus.IoInAck !== 1'b0) begin bad++; $display("FAIL io_ack_pulse got=%0b exp=0", bus.IoInAck); end
        bus.IoIn = 16'h0077; bus.IoInValid = 1'b1;
        tick();
        total++; if (bus.MemVal !== 16'h0042 || bus.IoInAck !== 1'b0 || bus.Stall !== 1'b0) begin
            bad++; $display("FAIL io_noread MemVal=%h ack=%0b stall=%0b exp=0042/0/0", bus.MemVal, bus.IoInAck, bus.Stall);
        end
        idle();
    endtask

    task automatic test_sweep_restart();
        int n;
        bus.Address = 9'd511; bus.DataIn = 16'h00C3; bus.MemWrite = 1'b1;
        tick();
        bus.Address = 9'd300; bus.DataIn = 16'hDEAD;
        tick();
        total++; if (bus.IoOutValid !== 1'b1) begin bad++; $display("FAIL pre_reset_valid got=%0b exp=1", bus.IoOutValid); end
        bus.MemWrite = 1'b0;
        do_reset();
        total++; if (bus.IoOutValid !== 1'b0) begin bad++; $display("FAIL reset_drops_io got=%0b exp=0", bus.IoOutValid); end
        // Strobes during the sweep must be ignored.
        bus.Address = 9'h10; bus.DataIn = 16'hFFFF; bus.MemWrite = 1'b1;
        for (int i = 0; i < 99; i++) tick();
        total++; if (bus.Stall !== 1'b1 || bus.Ready !== 1'b0) begin
            bad++; $display("FAIL mid_sweep Stall=%0b Ready=%0b exp=1/0", bus.Stall, bus.Ready);
        end
        idle();
        do_reset();
        wait_ready(n);
        total++; if (n !== 256) begin bad++; $display("FAIL restart_latency got=%0d exp=256", n); end
        total++; if (bus.IoOutValid !== 1'b0) begin bad++; $display("FAIL restart_io got=%0b exp=0", bus.IoOutValid); end
        bus.Address = 9'd300;
        tick();
        total++; if (bus.MemVal !== 16'h0) begin bad++; $display("FAIL restart_clear got=%h exp=0000", bus.MemVal); end
        bus.Address = 9'h10;
        tick();
        total++; if (bus.MemVal !== 16'h1234) begin bad++; $display("FAIL sweep_ignores_wr got=%h exp=1234", bus.MemVal); end
    endtask

    initial begin
        idle();
        bus.Address = '0; bus.FetchAddr = '0; bus.DataIn = '0; bus.IoIn = '0;
        test_reset();
        test_rw();
        test_write_wins();
        test_io_out();
        test_io_in();
        test_sweep_restart();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
